// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider sharing one reference clock.
// Each channel divides by its active ratio and switches ratios only at period boundaries.
module clk_div_multi #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned RATIO_WD  = 8,
    parameter int unsigned DEF_RATIO = 2
) (
    input  logic                         I_ref_clk,
    input  logic                         I_rst,
    input  logic [NUM_CH-1:0]            I_clk_en,
    input  logic [NUM_CH*RATIO_WD-1:0]   I_div_ratio,
    input  logic [NUM_CH-1:0]            I_ratio_load,
    input  logic                         I_sync,
    output logic [NUM_CH-1:0]            O_div_clk,
    output logic [NUM_CH-1:0]            O_tick,
    output logic [NUM_CH-1:0]            O_ratio_busy
);

    localparam int unsigned HW = RATIO_WD + 1;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [RATIO_WD-1:0] ratio_q;
        logic [RATIO_WD-1:0] ratio_d;
        logic [RATIO_WD-1:0] pend_q;
        logic [RATIO_WD-1:0] pend_d;
        logic                pend_vld_q;
        logic                pend_vld_d;
        logic [RATIO_WD-1:0] cnt_q;
        logic [RATIO_WD-1:0] cnt_d;
        logic                run_q;
        logic [RATIO_WD-1:0] slice;
        logic                at_end;
        logic                boundary;
        logic [HW-1:0]       half;

        assign slice    = I_div_ratio[k*RATIO_WD +: RATIO_WD];
        assign at_end   = (ratio_q >= RATIO_WD'(2)) && (cnt_q == ratio_q - RATIO_WD'(1));
        assign boundary = at_end || !run_q || (ratio_q <= RATIO_WD'(1)) || I_sync;

        // Ratio changes land only on a boundary, so every new period starts clean
        always_comb begin
            ratio_d    = ratio_q;
            pend_d     = pend_q;
            pend_vld_d = pend_vld_q;
            cnt_d      = cnt_q + RATIO_WD'(1);
            if (boundary || !I_clk_en[k]) begin
                cnt_d = '0;
            end
            if (I_ratio_load[k]) begin
                if (boundary) begin
                    ratio_d    = slice;
                    pend_vld_d = 1'b0;
                end else begin
                    pend_d     = slice;
                    pend_vld_d = 1'b1;
                end
            end else if (boundary && pend_vld_q) begin
                ratio_d    = pend_q;
                pend_vld_d = 1'b0;
            end
        end

        always_ff @(posedge I_ref_clk) begin
            if (I_rst) begin
                ratio_q    <= RATIO_WD'(DEF_RATIO);
                pend_q     <= '0;
                pend_vld_q <= 1'b0;
                cnt_q      <= '0;
                run_q      <= 1'b0;
            end else begin
                ratio_q    <= ratio_d;
                pend_q     <= pend_d;
                pend_vld_q <= pend_vld_d;
                cnt_q      <= cnt_d;
                run_q      <= I_clk_en[k];
            end
        end

        // Half-period in one extra bit so R at full scale cannot wrap
        assign half = (HW'(ratio_q) + HW'(1)) >> 1;

        assign O_div_clk[k]    = run_q && ((ratio_q == RATIO_WD'(1)) ? I_ref_clk
                                          : ((ratio_q >= RATIO_WD'(2)) && (HW'(cnt_q) < half)));
        assign O_tick[k]       = run_q && (ratio_q != '0) && (cnt_q == '0);
        assign O_ratio_busy[k] = pend_vld_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed plus random bench for clk_div_multi against a period-position reference model.
module tb_clk_div_multi;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned RATIO_WD  = 8;
    localparam int unsigned DEF_RATIO = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_CH-1:0]          en;
    logic [NUM_CH*RATIO_WD-1:0] ratio_bus;
    logic [NUM_CH-1:0]          load;
    logic                       sync;
    logic [NUM_CH-1:0]          div;
    logic [NUM_CH-1:0]          tick;
    logic [NUM_CH-1:0]          busy;

    int n_asrt = 0;
    int n_fail = 0;

    // Model: ratio, pending ratio, position inside current period
    int m_r   [NUM_CH];
    int m_p   [NUM_CH];
    int m_pos [NUM_CH];
    bit m_pend[NUM_CH];
    bit m_run [NUM_CH];

    int pat3[3] = '{1, 1, 0};
    int pat6[6] = '{1, 1, 1, 0, 0, 0};

    clk_div_multi #(
        .NUM_CH   (NUM_CH),
        .RATIO_WD (RATIO_WD),
        .DEF_RATIO(DEF_RATIO)
    ) dut (
        .I_ref_clk   (clk),
        .I_rst       (rst),
        .I_clk_en    (en),
        .I_div_ratio (ratio_bus),
        .I_ratio_load(load),
        .I_sync      (sync),
        .O_div_clk   (div),
        .O_tick      (tick),
        .O_ratio_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ratio(input int ch, input int v);
        ratio_bus[ch*RATIO_WD +: RATIO_WD] = RATIO_WD'(v);
    endtask

    function automatic int slice_of(input int ch);
        return int'(ratio_bus[ch*RATIO_WD +: RATIO_WD]);
    endfunction

    task automatic model_edge();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit period_end;
            bit bnd;
            if (rst) begin
                m_r[ch]    = DEF_RATIO;
                m_p[ch]    = 0;
                m_pend[ch] = 1'b0;
                m_pos[ch]  = 0;
                m_run[ch]  = 1'b0;
            end else begin
                period_end = m_run[ch] && (m_r[ch] >= 2) && (m_pos[ch] == m_r[ch] - 1);
                bnd        = period_end || !m_run[ch] || (m_r[ch] < 2) || sync;
                if (load[ch]) begin
                    if (bnd) begin
                        m_r[ch]    = slice_of(ch);
                        m_pend[ch] = 1'b0;
                    end else begin
                        m_p[ch]    = slice_of(ch);
                        m_pend[ch] = 1'b1;
                    end
                end else if (bnd && m_pend[ch]) begin
                    m_r[ch]    = m_p[ch];
                    m_pend[ch] = 1'b0;
                end
                m_pos[ch] = (en[ch] && !bnd) ? m_pos[ch] + 1 : 0;
                m_run[ch] = en[ch];
            end
        end
    endtask

    task automatic check_model();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit exp_div;
            bit exp_tick;
            if (m_r[ch] == 1) exp_div = m_run[ch] && clk;
            else              exp_div = m_run[ch] && (m_r[ch] >= 2) && (m_pos[ch] < (m_r[ch] + 1) / 2);
            exp_tick = m_run[ch] && (m_r[ch] != 0) && (m_pos[ch] == 0);
            check($sformatf("model_div%0d", ch),  32'(div[ch]),  32'(exp_div));
            check($sformatf("model_tick%0d", ch), 32'(tick[ch]), 32'(exp_tick));
            check($sformatf("model_busy%0d", ch), 32'(busy[ch]), 32'(m_pend[ch]));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        load = '0;
        sync = 1'b0;
    endtask

    initial begin
        int hi_first;
        int hi_rest;
        int lo_cnt;
        int gap;
        int c;

        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_r[ch] = 0; m_p[ch] = 0; m_pos[ch] = 0; m_pend[ch] = 1'b0; m_run[ch] = 1'b0;
        end
        rst = 1'b1; en = '0; load = '0; sync = 1'b0; ratio_bus = '0;
        cyc();
        cyc();
        check("rst_div",  32'(div),  32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        cyc();

        // Ch0 ratio 3 loaded while idle, then enabled
        set_ratio(0, 3); load[0] = 1'b1;
        cyc();
        check("idle_load_busy0", 32'(busy[0]), 32'h0);
        en[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            check($sformatf("r3_div_%0d", i),  32'(div[0]),  32'(pat3[i % 3]));
            check($sformatf("r3_tick_%0d", i), 32'(tick[0]), 32'((i % 3) == 0));
        end

        // Ch1 ratio 4 running, reload to 6 mid-period
        set_ratio(1, 4); load[1] = 1'b1; en[1] = 1'b1;
        cyc();
        check("r4_start_tick1", 32'(tick[1]), 32'h1);
        set_ratio(1, 6); load[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("r4to6_busy_%0d", i), 32'(busy[1]), 32'h1);
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            check($sformatf("r6_busy_%0d", i), 32'(busy[1]), 32'h0);
            check($sformatf("r6_div_%0d", i),  32'(div[1]),  32'(pat6[i]));
        end

        // Ch2 bypass, then switched off
        set_ratio(2, 1); load[2] = 1'b1; en[2] = 1'b1;
        cyc();
        cyc();
        check("byp_div_hi",  32'(div[2]),  32'h1);
        check("byp_tick_hi", 32'(tick[2]), 32'h1);
        @(negedge clk); #1;
        check("byp_div_lo",  32'(div[2]),  32'h0);
        check("byp_tick_lo", 32'(tick[2]), 32'h1);
        set_ratio(2, 0); load[2] = 1'b1;
        cyc();
        check("off_div2",  32'(div[2]),  32'h0);
        check("off_tick2", 32'(tick[2]), 32'h0);
        cyc();

        // Ratios 2,3,5 out of phase, sync aligns them
        set_ratio(1, 5); load[1] = 1'b1;
        set_ratio(2, 2); load[2] = 1'b1;
        cyc();
        for (int r = 0; r < 3; r++) begin
            gap = int'($urandom_range(3, 11));
            for (int i = 0; i < gap; i++) cyc();
            sync = 1'b1;
            cyc();
            check($sformatf("sync_tick_%0d", r), 32'(tick[2:0]), 32'h7);
            check($sformatf("sync_div_%0d", r),  32'(div[2:0]),  32'h7);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                c = int'($urandom_range(0, NUM_CH - 1));
                en[c] = ~en[c];
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(0, 5) == 0) begin
                    load[ch] = 1'b1;
                    set_ratio(ch, int'($urandom_range(0, 9)));
                end
            end
            sync = ($urandom_range(0, 19) == 0);
            cyc();
        end

        // Full-scale ratio 255 on ch3
        en = '0;
        cyc();
        set_ratio(0, 3); set_ratio(1, 5); set_ratio(2, 2); set_ratio(3, 255);
        load = '1; en = '1;
        cyc();
        hi_first = 0; hi_rest = 0; lo_cnt = 0;
        for (int i = 0; i < 255; i++) begin
            if (i < 128) hi_first += int'(div[3]);
            else         hi_rest  += int'(div[3]);
            if (!div[3]) lo_cnt++;
            cyc();
        end
        check("r255_high_first", 32'(hi_first), 32'd128);
        check("r255_high_rest",  32'(hi_rest),  32'd0);
        check("r255_low",        32'(lo_cnt),   32'd127);
        check("r255_wrap_tick",  32'(tick[3]),  32'h1);

        // Reset mid-period with load, sync and enable active
        cyc(); cyc(); cyc();
        set_ratio(3, 7); load[3] = 1'b1;
        cyc();
        check("pre_rst_busy3", 32'(busy[3]), 32'h1);
        rst = 1'b1; load = '1; sync = 1'b1;
        for (int ch = 0; ch < NUM_CH; ch++) set_ratio(ch, int'($urandom_range(3, 9)));
        cyc();
        check("mid_rst_div",  32'(div),  32'h0);
        check("mid_rst_tick", 32'(tick), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0; en = '0;
        cyc();
        check("post_rst_div", 32'(div), 32'h0);
        en = '1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("def_div_%0d", i),  32'(div),  ((i % 2) == 0) ? 32'hF : 32'h0);
            check($sformatf("def_tick_%0d", i), 32'(tick), ((i % 2) == 0) ? 32'hF : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
